serial_divisibility_by_n: RTL and testbench

Parametrised serial divisibility checker: consumes a binary number one bit per valid beat and tracks its remainder modulo a compile-time `DIVISOR`. It generalises the fixed divide-by-3/5 FSMs in the finite-state-machine section: arbitrary divisor, framed input with start/last markers, valid-gated bits, and a registered per-frame result. It sits behind a serial bit source, such as a deserialiser or bit-bang front end, and feeds control logic that needs a divisibility verdict per frame.

---
 rtl/serial_divisibility_by_n.sv | 148 ++++++++++++++
 tb/tb_serial_divisibility_by_n.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/serial_divisibility_by_n.sv
// Serial divisibility checker: folds one bit per valid beat into a remainder modulo DIVISOR, with framed per-frame results.
// Optional LSB-first frame support is built when SERIAL_DIV_LSB_FIRST_EN is defined.
module serial_divisibility_by_n #(
    parameter int DIVISOR = 7,
    parameter int RW      = $clog2(DIVISOR)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          new_bit,
    input  logic          in_start,
    input  logic          in_last,
    input  logic          lsb_first,
    output logic [RW-1:0] rem,
    output logic          div_by_n,
    output logic          result_valid,
    output logic          result_div,
    output logic [RW-1:0] result_rem,
    output logic          busy
);

    generate
        if (DIVISOR < 2 || DIVISOR > 1024) begin : g_bad_divisor
            $error("serial_divisibility_by_n: DIVISOR must be in 2..1024");
        end
    endgenerate

    localparam logic [RW:0] DIV_EXT = (RW+1)'(DIVISOR);

    // Inputs are always < 2*DIVISOR, so a single conditional subtract is a full reduction.
    function automatic logic [RW-1:0] mod_reduce(input logic [RW:0] v);
        logic [RW:0] r;
        if (v >= DIV_EXT) begin
            r = v - DIV_EXT;
        end else begin
            r = v;
        end
        return r[RW-1:0];
    endfunction

    logic [RW-1:0] rem_q, rem_d;
    logic          busy_q, busy_d;
    logic          result_valid_q, result_valid_d;
    logic          result_div_q, result_div_d;
    logic [RW-1:0] result_rem_q, result_rem_d;

    logic [RW-1:0] base_rem_s;
    logic [RW-1:0] msb_rem_s;
    logic [RW-1:0] upd_rem_s;

`ifdef SERIAL_DIV_LSB_FIRST_EN
    localparam logic [RW-1:0] WEIGHT_ONE = RW'(1);

    logic [RW-1:0] weight_q, weight_d;
    logic          order_q, order_d;
    logic [RW-1:0] base_weight_s;
    logic [RW-1:0] lsb_rem_s;
    logic [RW-1:0] weight_next_s;
    logic          order_s;

    // LSB-first datapath: add the current power-of-two weight, then double it modulo DIVISOR.
    always_comb begin
        base_weight_s = in_start ? WEIGHT_ONE : weight_q;
        order_s       = in_start ? lsb_first : order_q;
        lsb_rem_s     = mod_reduce({1'b0, base_rem_s} + (new_bit ? {1'b0, base_weight_s} : {(RW+1){1'b0}}));
        weight_next_s = mod_reduce({base_weight_s, 1'b0});
        if (in_valid) begin
            weight_d = weight_next_s;
            order_d  = order_s;
        end else begin
            weight_d = weight_q;
            order_d  = order_q;
        end
    end

    // Weight and bit-order state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weight_q <= WEIGHT_ONE;
            order_q  <= 1'b0;
        end else begin
            weight_q <= weight_d;
            order_q  <= order_d;
        end
    end

    assign upd_rem_s = order_s ? lsb_rem_s : msb_rem_s;
`else
    logic unused_lsb_first_s;
    assign unused_lsb_first_s = lsb_first;
    assign upd_rem_s          = msb_rem_s;
`endif

    // MSB-first datapath: 2*rem + bit is just the concatenation, then reduce.
    always_comb begin
        base_rem_s = in_start ? {RW{1'b0}} : rem_q;
        msb_rem_s  = mod_reduce({base_rem_s, new_bit});
    end

    // Next-state for remainder, frame tracking and the per-frame result.
    always_comb begin
        rem_d          = rem_q;
        busy_d         = busy_q;
        result_valid_d = 1'b0;
        result_div_d   = result_div_q;
        result_rem_d   = result_rem_q;
        if (in_valid) begin
            rem_d = upd_rem_s;
            if (in_last) begin
                busy_d         = 1'b0;
                result_valid_d = 1'b1;
                result_div_d   = (upd_rem_s == {RW{1'b0}});
                result_rem_d   = upd_rem_s;
            end else if (in_start) begin
                busy_d = 1'b1;
            end else begin
                busy_d = busy_q;
            end
        end else begin
            rem_d = rem_q;
        end
    end

    // Main state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q          <= {RW{1'b0}};
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_div_q   <= 1'b0;
            result_rem_q   <= {RW{1'b0}};
        end else begin
            rem_q          <= rem_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            result_div_q   <= result_div_d;
            result_rem_q   <= result_rem_d;
        end
    end

    assign rem          = rem_q;
    assign div_by_n     = (rem_q == {RW{1'b0}});
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign result_div   = result_div_q;
    assign result_rem   = result_rem_q;

endmodule

// File: tb/tb_serial_divisibility_by_n.sv
// Directed bench for serial_divisibility_by_n: three instances (DIVISOR 3, 5, 7) share one serial stimulus stream.
module tb_serial_divisibility_by_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, new_bit = 1'b0, in_start = 1'b0, in_last = 1'b0, lsb_first = 1'b0;

    logic [1:0] rem3, rrem3;
    logic [2:0] rem5, rrem5, rem7, rrem7;
    logic div3, rv3, rdiv3, busy3;
    logic div5, rv5, rdiv5, busy5;
    logic div7, rv7, rdiv7, busy7;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_divisibility_by_n #(.DIVISOR(3)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .new_bit(new_bit), .in_start(in_start),
        .in_last(in_last), .lsb_first(lsb_first), .rem(rem3), .div_by_n(div3),
        .result_valid(rv3), .result_div(rdiv3), .result_rem(rrem3), .busy(busy3));
    serial_divisibility_by_n #(.DIVISOR(5)) u5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .new_bit(new_bit), .in_start(in_start),
        .in_last(in_last), .lsb_first(lsb_first), .rem(rem5), .div_by_n(div5),
        .result_valid(rv5), .result_div(rdiv5), .result_rem(rrem5), .busy(busy5));
    serial_divisibility_by_n #(.DIVISOR(7)) u7 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .new_bit(new_bit), .in_start(in_start),
        .in_last(in_last), .lsb_first(lsb_first), .rem(rem7), .div_by_n(div7),
        .result_valid(rv7), .result_div(rdiv7), .result_rem(rrem7), .busy(busy7));

    // Drive one cycle on the falling edge, then land 1 ns after the rising edge for sampling.
    task automatic beat(input logic v, input logic b, input logic s, input logic l);
        @(negedge clk);
        in_valid = v; new_bit = b; in_start = s; in_last = l;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rem7 !== 3'd0) begin errors++; $display("FAIL reset_rem got=%0d exp=0", rem7); end
        checks++; if (div7 !== 1'b1) begin errors++; $display("FAIL reset_div_by_n got=%0b exp=1", div7); end
        checks++; if (busy7 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy7); end
        checks++; if (rv7 !== 1'b0) begin errors++; $display("FAIL reset_result_valid got=%0b exp=0", rv7); end
        checks++; if (rdiv7 !== 1'b0 || rrem7 !== 3'd0) begin errors++; $display("FAIL reset_result got div=%0b rem=%0d exp div=0 rem=0", rdiv7, rrem7); end
        rst = 1'b0;
    endtask

    task automatic test_msb_div5();
        logic [2:0] exp_rem [4];
        logic       b_seq   [4];
        exp_rem = '{3'd1, 3'd2, 3'd0, 3'd0};
        b_seq   = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, b_seq[i], i == 0, i == 3);
            checks++; if (rem5 !== exp_rem[i]) begin errors++; $display("FAIL msb5_rem beat%0d got=%0d exp=%0d", i, rem5, exp_rem[i]); end
            checks++; if (busy5 !== (i != 3)) begin errors++; $display("FAIL msb5_busy beat%0d got=%0b exp=%0b", i, busy5, i != 3); end
            checks++; if (rv5 !== (i == 3)) begin errors++; $display("FAIL msb5_pulse beat%0d got=%0b exp=%0b", i, rv5, i == 3); end
        end
        checks++; if (rdiv5 !== 1'b1 || rrem5 !== 3'd0) begin errors++; $display("FAIL msb5_result got div=%0b rem=%0d exp div=1 rem=0", rdiv5, rrem5); end
        beat(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (rv5 !== 1'b0) begin errors++; $display("FAIL msb5_pulse_width got=%0b exp=0", rv5); end
        checks++; if (rdiv5 !== 1'b1) begin errors++; $display("FAIL msb5_result_held got=%0b exp=1", rdiv5); end
    endtask

    task automatic test_gap_div7();
        beat(1'b1, 1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (rem7 !== 3'd3) begin errors++; $display("FAIL gap7_rem_b2 got=%0d exp=3", rem7); end
        for (int i = 0; i < 3; i++) begin
            beat(1'b0, 1'b1, 1'b0, 1'b0);
            checks++; if (rem7 !== 3'd3) begin errors++; $display("FAIL gap7_hold idle%0d got=%0d exp=3", i, rem7); end
        end
        beat(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (rem7 !== 3'd6) begin errors++; $display("FAIL gap7_rem_b3 got=%0d exp=6", rem7); end
        beat(1'b1, 1'b1, 1'b0, 1'b1);
        checks++; if (rem7 !== 3'd6 || rv7 !== 1'b1) begin errors++; $display("FAIL gap7_last got rem=%0d rv=%0b exp rem=6 rv=1", rem7, rv7); end
        checks++; if (rdiv7 !== 1'b0 || rrem7 !== 3'd6) begin errors++; $display("FAIL gap7_result got div=%0b rem=%0d exp div=0 rem=6", rdiv7, rrem7); end
    endtask

    task automatic test_lsb_order();
        logic [2:0] exp7;
        logic [2:0] exp5;
`ifdef SERIAL_DIV_LSB_FIRST_EN
        exp7 = 3'd6; exp5 = 3'd3;
`else
        exp7 = 3'd4; exp5 = 3'd1;
`endif
        lsb_first = 1'b1;
        beat(1'b1, 1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b0, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 1'b0, 1'b1);
        lsb_first = 1'b0;
        checks++; if (rrem7 !== exp7) begin errors++; $display("FAIL lsb7_result got=%0d exp=%0d", rrem7, exp7); end
        checks++; if (rrem5 !== exp5) begin errors++; $display("FAIL lsb5_result got=%0d exp=%0d", rrem5, exp5); end
        // Next frame restarts in MSB order even though the previous one may have been LSB.
        beat(1'b1, 1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b1, 1'b0, 1'b1);
        checks++; if (rrem7 !== 3'd3) begin errors++; $display("FAIL order_reload got=%0d exp=3", rrem7); end
    endtask

    task automatic test_single_beat();
        beat(1'b1, 1'b1, 1'b1, 1'b1);
        checks++; if (rv3 !== 1'b1 || rrem3 !== 2'd1) begin errors++; $display("FAIL single3 got rv=%0b rem=%0d exp rv=1 rem=1", rv3, rrem3); end
        checks++; if (busy3 !== 1'b0 || rdiv3 !== 1'b0) begin errors++; $display("FAIL single3_busy_div got busy=%0b div=%0b exp 0 0", busy3, rdiv3); end
        beat(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (rv3 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL single3_after got rv=%0b busy=%0b exp 0 0", rv3, busy3); end
    endtask

    task automatic test_abort();
        beat(1'b1, 1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (rem5 !== 3'd3 || rem3 !== 2'd0) begin errors++; $display("FAIL abort_pre got rem5=%0d rem3=%0d exp 3 0", rem5, rem3); end
        beat(1'b1, 1'b0, 1'b1, 1'b0);
        checks++; if (rem5 !== 3'd0 || rem3 !== 2'd0) begin errors++; $display("FAIL abort_reseed got rem5=%0d rem3=%0d exp 0 0", rem5, rem3); end
        checks++; if (busy3 !== 1'b1 || rv3 !== 1'b0 || rv5 !== 1'b0) begin errors++; $display("FAIL abort_flags got busy=%0b rv3=%0b rv5=%0b exp 1 0 0", busy3, rv3, rv5); end
    endtask

    task automatic test_back_to_back();
        beat(1'b1, 1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b1, 1'b0, 1'b1);
        checks++; if (rv5 !== 1'b1 || rrem5 !== 3'd3 || rdiv5 !== 1'b0) begin errors++; $display("FAIL b2b_a got rv=%0b rem=%0d div=%0b exp 1 3 0", rv5, rrem5, rdiv5); end
        beat(1'b1, 1'b1, 1'b1, 1'b0);
        checks++; if (rv5 !== 1'b0 || busy5 !== 1'b1 || rem5 !== 3'd1) begin errors++; $display("FAIL b2b_start got rv=%0b busy=%0b rem=%0d exp 0 1 1", rv5, busy5, rem5); end
        beat(1'b1, 1'b0, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 1'b0, 1'b1);
        checks++; if (rv5 !== 1'b1 || rrem5 !== 3'd0 || rdiv5 !== 1'b1) begin errors++; $display("FAIL b2b_b got rv=%0b rem=%0d div=%0b exp 1 0 1", rv5, rrem5, rdiv5); end
        checks++; if (rrem7 !== 3'd5) begin errors++; $display("FAIL b2b_b7 got=%0d exp=5", rrem7); end
    endtask

    task automatic test_free_run();
        beat(1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (rem7 !== 3'd4 || busy7 !== 1'b0 || rv7 !== 1'b0) begin errors++; $display("FAIL free7 got rem=%0d busy=%0b rv=%0b exp 4 0 0", rem7, busy7, rv7); end
        beat(1'b0, 1'b1, 1'b1, 1'b1);
        checks++; if (rem7 !== 3'd4 || busy7 !== 1'b0 || rv7 !== 1'b0) begin errors++; $display("FAIL ignored_markers got rem=%0d busy=%0b rv=%0b exp 4 0 0", rem7, busy7, rv7); end
    endtask

    task automatic test_async_reset();
        beat(1'b1, 1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0; in_start = 1'b0; in_last = 1'b0;
        checks++; if (rem7 !== 3'd3 || busy7 !== 1'b1) begin errors++; $display("FAIL areset_pre got rem=%0d busy=%0b exp 3 1", rem7, busy7); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (rem7 !== 3'd0 || div7 !== 1'b1) begin errors++; $display("FAIL areset_rem got rem=%0d div=%0b exp 0 1", rem7, div7); end
        checks++; if (busy7 !== 1'b0 || rv7 !== 1'b0 || rrem7 !== 3'd0) begin errors++; $display("FAIL areset_flags got busy=%0b rv=%0b rrem=%0d exp 0 0 0", busy7, rv7, rrem7); end
        @(negedge clk);
        rst = 1'b0;
        beat(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (rv7 !== 1'b0 || rem7 !== 3'd0) begin errors++; $display("FAIL areset_after got rv=%0b rem=%0d exp 0 0", rv7, rem7); end
    endtask

    initial begin
        test_reset();
        test_msb_div5();
        test_gap_div7();
        test_lsb_order();
        test_single_beat();
        test_abort();
        test_back_to_back();
        test_free_run();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
